ysyx_23060184_pipe_ctrl: RTL
============================

# ysyx_23060184_pipe_ctrl

Pipeline sequencing controller for the five-stage core. It takes the redirect indication from the forwarding/hazard logic, the D/E register identifiers, the instruction-fetch handshake and the data-memory handshake. It produces every stall, flush and bubble control for the IF/ID/EX/MEM/WB registers. It also tracks wrong-path fetches and memory-wait timeouts, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_LENGTH, 5, register-index width
- TIMEOUT, 255, consecutive memory-busy cycles before Timeout sets (≥2)
- CNT_WIDTH, 32, stall counter width

Ports:
- clk  in  1  rising-edge clock; the block uses this one clock only
- rstn  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_LENGTH  source registers in D
- RdE  in  REG_LENGTH  destination register in E
- MemReadE  in  1  E holds a load
- Branch  in  1  E redirects the PC this cycle
- IfetchValid  in  1  fetch returns an instruction this cycle
- DmemReqM  in  1  M has a memory access
- DmemReadyM  in  1  memory completes this cycle
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE  out  1  load bubble into stage register
- BubbleW  out  1  load bubble into W register
- DropF  out  1  discard the instruction returned this cycle
- Timeout  out  1  sticky memory-watchdog error
- StallCount  out  CNT_WIDTH  cycles with StallF=1, saturating

## Operation
- Define MemBusy = DmemReqM & ~DmemReadyM.
- Define LoadUse = MemReadE & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- FSM states are RUN, MWAIT, IWAIT and DRAIN. The encoding is in the shared defines.
- Control outputs are combinational. Apply the first matching row below:
  1. MemBusy: StallF=StallD=StallE=StallM=1, BubbleW=1, all flushes 0.
  2. Branch: FlushD=FlushE=1, no stalls. The PC loads the target this edge.
  3. LoadUse: StallF=StallD=1, FlushE=1.
  4. ~IfetchValid, or state DRAIN: StallF=1, FlushD=1.
  5. Otherwise all controls are 0.
- DropF = (state==DRAIN) & IfetchValid. This is independent of the priority rows.
- Next-state transitions:
  - MemBusy → MWAIT.
  - Branch & ~IfetchValid → DRAIN, because the outstanding fetch is wrong-path.
  - DRAIN holds until IfetchValid, then goes to RUN, or to MWAIT if MemBusy.
  - MWAIT & ~MemBusy → RUN, or to DRAIN if the DRAIN condition is pending.
  - ~IfetchValid otherwise → IWAIT.
  - IWAIT & IfetchValid → RUN.
- DRAIN takes precedence over IWAIT. A pending DRAIN survives an interleaved MWAIT in a dedicated pending flag.
- Watchdog counter:
  - It counts consecutive MemBusy cycles and clears on ~MemBusy.
  - Timeout sets when the counter equals TIMEOUT-1 and MemBusy is still 1.
  - Timeout clears only on reset.
- StallCount increments on every cycle with StallF=1 and holds at 2^CNT_WIDTH−1.

## Timing
- Stall, flush, bubble and DropF outputs have zero-cycle latency from their inputs.
- State, the pending flag, the watchdog, Timeout and StallCount update on the clk rising edge.
- Reset (rstn=0, asynchronous, any cycle, including mid-MWAIT or mid-DRAIN):
  - State goes to RUN, and the pending flag, watchdog, Timeout and StallCount go to 0.
  - All outputs are forced to 0 while rstn=0.
- Timeout is visible on the edge after TIMEOUT consecutive MemBusy cycles.
- Branch and LoadUse in the same cycle: the branch wins. E is flushed and D is not stalled.
- Branch during MemBusy: the branch is ignored this cycle. E is frozen, so Branch is re-presented after the memory completes.

## Structure
- The shared defines file owns:
  - REG_LENGTH
  - the FSM state width and encodings (PCTRL_RUN/MWAIT/IWAIT/DRAIN)
  - the PC_SRC encodings already used for Branch generation
- Sub-module ysyx_23060184_sat_counter (parameters WIDTH and a saturate enable) is instantiated twice: for StallCount and for the watchdog (with synchronous clear).
- The FSM and the priority decode stay in the top module.

## Test plan
- RdE=5, MemReadE=1, Rs1D=5, IfetchValid=1 → StallF=StallD=FlushE=1 for one cycle, then all 0. RdE=0 with Rs1D=0 → no stall.
- MemReadE=1, RdE=Rs1D=7 and Branch=1 in the same cycle → FlushD=FlushE=1, StallD=0.
- DmemReqM=1 and DmemReadyM=0 for 3 cycles, then DmemReadyM=1:
  - StallF..StallM=BubbleW=1 for exactly those 3 cycles, and the state returns to RUN.
  - StallCount = 3.
- Branch=1 with IfetchValid=0, then IfetchValid=0 for 2 cycles, then IfetchValid=1:
  - DropF=1 exactly on the return cycle, FlushD=1 throughout, then RUN.
- TIMEOUT=4 with MemBusy held for 5 cycles → Timeout=1 from edge 4. It remains 1 after MemBusy drops, and clears only when rstn is pulsed.
- rstn pulsed low mid-DRAIN → next IfetchValid gives DropF=0. StallCount=0.
- Saturation: force StallF for 2^CNT_WIDTH+2 cycles (CNT_WIDTH=4 build) → StallCount=15.

Source files
------------

// File: rtl/ysyx_23060184_pipe_ctrl_pkg.sv
// Shared defines for the pipeline sequencing controller.
// Owns the register-index width, the controller FSM state width and encodings,
// and the PC source encodings used when the branch unit generates Branch.
package ysyx_23060184_pipe_ctrl_pkg;

   localparam int REG_LENGTH    = 5;
   localparam int PCTRL_STATE_W = 2;

   typedef enum logic [PCTRL_STATE_W-1:0] {
      PCTRL_RUN   = 2'd0,
      PCTRL_MWAIT = 2'd1,
      PCTRL_IWAIT = 2'd2,
      PCTRL_DRAIN = 2'd3
   } pctrlState_t;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'd0,
      PC_SRC_BRANCH = 2'd1,
      PC_SRC_JALR   = 2'd2,
      PC_SRC_TRAP   = 2'd3
   } pcSrc_t;

endpackage

// File: rtl/ysyx_23060184_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset, clears count
//   clr   - synchronous clear, wins over inc
//   inc   - count up by one this cycle
//   count - current value
module ysyx_23060184_sat_counter #(
   parameter int WIDTH    = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = '1;

   logic atMax;
   assign atMax = SATURATE && (count == COUNT_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !atMax) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ysyx_23060184_pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage core.
// Produces stall/flush/bubble controls for the IF/ID/EX/MEM/WB registers from
// the redirect, load-use, fetch and data-memory handshakes; tracks wrong-path
// fetches, a sticky memory-wait watchdog and a saturating stall-cycle counter.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   Rs1D, Rs2D, RdE, MemReadE - load-use hazard inputs
//   Branch                    - E redirects the PC this cycle
//   IfetchValid               - fetch returns an instruction this cycle
//   DmemReqM, DmemReadyM      - data-memory handshake in M
//   StallF..StallM            - hold stage registers
//   FlushD, FlushE, BubbleW   - load bubbles
//   DropF                     - discard the wrong-path instruction returned now
//   Timeout                   - sticky memory watchdog error
//   StallCount                - saturating count of StallF cycles
//
// state | meaning
// RUN   | normal flow, fetch delivering
// MWAIT | data memory busy, whole pipe frozen
// IWAIT | waiting on an in-order fetch
// DRAIN | outstanding fetch is wrong-path; drop it when it returns
module ysyx_23060184_pipe_ctrl #(
   parameter int REG_LENGTH = ysyx_23060184_pipe_ctrl_pkg::REG_LENGTH,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [REG_LENGTH-1:0] Rs1D,
   input  logic [REG_LENGTH-1:0] Rs2D,
   input  logic [REG_LENGTH-1:0] RdE,
   input  logic                  MemReadE,
   input  logic                  Branch,
   input  logic                  IfetchValid,
   input  logic                  DmemReqM,
   input  logic                  DmemReadyM,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  BubbleW,
   output logic                  DropF,
   output logic                  Timeout,
   output logic [CNT_WIDTH-1:0]  StallCount
);

   import ysyx_23060184_pipe_ctrl_pkg::*;

   localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

   pctrlState_t         state;
   pctrlState_t         stateNext;
   logic                drainPend;
   logic                drainPendNext;
   logic                memBusy;
   logic                loadUse;
   logic [WD_WIDTH-1:0] wdCount;
   logic                timeoutReg;

   assign memBusy = DmemReqM & ~DmemReadyM;
   assign loadUse = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

   // Priority decode; everything is held at 0 while reset is asserted.
   always_comb begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      BubbleW = 1'b0;
      DropF   = 1'b0;
      if (rstn) begin
         DropF = (state == PCTRL_DRAIN) & IfetchValid;
         if (memBusy) begin
            // E is frozen, so a Branch here is simply re-presented later.
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            StallM  = 1'b1;
            BubbleW = 1'b1;
         end else if (Branch) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (loadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else if (!IfetchValid || (state == PCTRL_DRAIN)) begin
            StallF = 1'b1;
            FlushD = 1'b1;
         end
      end
   end

   always_comb begin
      stateNext     = state;
      drainPendNext = drainPend;
      if (memBusy) begin
         stateNext = PCTRL_MWAIT;
         // Remember an unreturned wrong-path fetch across the memory wait.
         drainPendNext = ((state == PCTRL_DRAIN) & ~IfetchValid) |
                         ((state == PCTRL_MWAIT) & drainPend);
      end else if (state == PCTRL_MWAIT) begin
         drainPendNext = 1'b0;
         if (drainPend || (Branch && !IfetchValid)) begin
            stateNext = PCTRL_DRAIN;
         end else begin
            stateNext = PCTRL_RUN;
         end
      end else if (Branch && !IfetchValid) begin
         stateNext = PCTRL_DRAIN;
      end else if (state == PCTRL_DRAIN) begin
         stateNext = IfetchValid ? PCTRL_RUN : PCTRL_DRAIN;
      end else if (!IfetchValid) begin
         stateNext = PCTRL_IWAIT;
      end else begin
         stateNext = PCTRL_RUN;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= PCTRL_RUN;
         drainPend <= 1'b0;
      end else begin
         state     <= stateNext;
         drainPend <= drainPendNext;
      end
   end

   // Watchdog holds the number of consecutive busy cycles already completed,
   // so it reads TIMEOUT-1 during the TIMEOUT-th busy cycle.
   ysyx_23060184_sat_counter #(
      .WIDTH    (WD_WIDTH),
      .SATURATE (1'b1)
   ) uWatchdog (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (~memBusy),
      .inc   (memBusy),
      .count (wdCount)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timeoutReg <= 1'b0;
      end else if (memBusy && (wdCount == WD_WIDTH'(TIMEOUT - 1))) begin
         timeoutReg <= 1'b1;
      end
   end

   assign Timeout = timeoutReg;

   ysyx_23060184_sat_counter #(
      .WIDTH    (CNT_WIDTH),
      .SATURATE (1'b1)
   ) uStallCount (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (1'b0),
      .inc   (StallF),
      .count (StallCount)
   );

endmodule
